// File: rtl/kf76489_pkg.sv
// Shared definitions for the kf76489 PSG channels: field widths, the
// attenuation-to-amplitude table and the TI bit-order helper.
package kf76489_pkg;

    localparam int BUS_W  = 8;
    localparam int FREQ_W = 10;
    localparam int ATT_W  = 4;
    localparam int AMP_W  = 6;

    // Attenuation steps are 2 dB; index 15 is silence. The table is sized for
    // a 6-bit index so a wider attenuation path can reuse it; entries 16..63
    // are zero. Packed layout: entry 0 is the least significant slice.
    localparam logic [63:0][AMP_W-1:0] VOL_TABLE = {
        {48{6'd0}},
        6'd0,  6'd3,  6'd3,  6'd4,  6'd5,  6'd6,  6'd8,  6'd10,
        6'd13, 6'd16, 6'd20, 6'd25, 6'd32, 6'd40, 6'd50, 6'd63
    };

    // The internal bus carries chip D0 on bit 7; reversing the byte puts
    // chip D0 on bit 0 so register fields can be sliced off the low end.
    function automatic logic [BUS_W-1:0] bit_reverse8(input logic [BUS_W-1:0] v);
        logic [BUS_W-1:0] r;
        r = '0;
        for (int i = 0; i < BUS_W; i++) begin
            r[i] = v[BUS_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/kf76489_tone_channel_if.sv
// Register-decoder side of a tone channel: shared write data plus the
// per-register write strobes.
interface kf76489_tone_channel_if;
    logic [7:0] internal_data_bus;
    logic       write_frequency_h;
    logic       write_frequency_l;
    logic       write_attenuation;

    modport master (
        output internal_data_bus,
        output write_frequency_h,
        output write_frequency_l,
        output write_attenuation
    );

    modport slave (
        input internal_data_bus,
        input write_frequency_h,
        input write_frequency_l,
        input write_attenuation
    );
endinterface

// File: rtl/kf76489_tone_channel.sv
// One SN76489-style square-wave tone channel: 10-bit reload divider ticked
// by clock_enable, a toggling tone flip-flop and a registered attenuated
// amplitude output.
module kf76489_tone_channel
    import kf76489_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clock_enable,
    kf76489_tone_channel_if.slave   bus_if,
    output logic                    cycle_out,
    output logic [AMP_W-1:0]        analog_out
);

    logic [FREQ_W-1:0] frequency;
    logic [ATT_W-1:0]  attenuation;
    logic [FREQ_W-1:0] counter;
    logic              tone_ff;
    logic [BUS_W-1:0]  bus_rev;
    logic              reload;
    logic              unused_bus_bits;

    // Bus in chip bit order: bus_rev[0] is chip D0.
    assign bus_rev = bit_reverse8(bus_if.internal_data_bus);

    // The top two reversed bits (bus[1:0]) belong to no field.
    assign unused_bus_bits = ^bus_rev[7:6];

    // Counter values 0 and 1 both reload, so frequency 0 behaves as 1.
    assign reload = (counter <= FREQ_W'(1));

    // Register writes; independent of clock_enable and may coincide.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frequency   <= '0;
            attenuation <= '1;
        end else begin
            if (bus_if.write_frequency_h) begin
                frequency[3:0] <= bus_rev[3:0];
            end
            if (bus_if.write_frequency_l) begin
                frequency[9:4] <= bus_rev[5:0];
            end
            if (bus_if.write_attenuation) begin
                attenuation <= bus_rev[3:0];
            end
        end
    end

    // Divider: count down on enable ticks, reload and toggle at the bottom.
    // A new frequency is only picked up at the next reload.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counter   <= '0;
            tone_ff   <= 1'b0;
            cycle_out <= 1'b0;
        end else if (clock_enable) begin
            if (reload) begin
                counter   <= frequency;
                tone_ff   <= ~tone_ff;
                cycle_out <= 1'b1;
            end else begin
                counter   <= counter - FREQ_W'(1);
                cycle_out <= 1'b0;
            end
        end else begin
            cycle_out <= 1'b0;
        end
    end

    // Output stage: one clock behind the flip-flop and attenuation register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            analog_out <= '0;
        end else begin
            analog_out <= tone_ff ? VOL_TABLE[{2'b00, attenuation}] : '0;
        end
    end

endmodule

// File: tb/tb_kf76489_tone_channel.sv
// Self-checking bench for kf76489_tone_channel: directed steps plus random
// traffic, compared every clock against a tick-count model of the channel.
module tb_kf76489_tone_channel;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       clock_enable = 1'b0;
    logic       cycle_out;
    logic [5:0] analog_out;

    kf76489_tone_channel_if bus_if();

    kf76489_tone_channel dut (
        .clock        (clock),
        .reset        (reset),
        .clock_enable (clock_enable),
        .bus_if       (bus_if.slave),
        .cycle_out    (cycle_out),
        .analog_out   (analog_out)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_cnt = 0;

    int vol_ref [16] = '{63, 50, 40, 32, 25, 20, 16, 13, 10, 8, 6, 5, 4, 3, 3, 0};

    // Reference model: m_rem = enable ticks left until the next toggle.
    int m_freq, m_att, m_rem, m_amp;
    bit m_tone, m_cyc;

    function automatic void model_reset();
        m_freq = 0; m_att = 15; m_rem = 1;
        m_tone = 0; m_cyc = 0;  m_amp = 0;
    endfunction

    function automatic int field(logic [7:0] d, int n);
        int v = 0;
        for (int i = 0; i < n; i++) if (d[7-i]) v += (1 << i);
        return v;
    endfunction

    function automatic void model_edge(bit ce, logic [7:0] d, bit wh, bit wl, bit wa);
        m_amp = m_tone ? vol_ref[m_att] : 0;
        m_cyc = 0;
        if (ce) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_tone = !m_tone;
                m_rem  = (m_freq == 0) ? 1 : m_freq;
                m_cyc  = 1;
            end
        end
        if (wh) m_freq = (m_freq & ~15) | field(d, 4);
        if (wl) m_freq = (m_freq & 15) | (field(d, 6) << 4);
        if (wa) m_att  = field(d, 4);
    endfunction

    function automatic logic [7:0] enc_low4(int v);
        logic [7:0] b = '0;
        for (int i = 0; i < 4; i++) b[7-i] = v[i];
        return b;
    endfunction

    function automatic logic [7:0] enc_high6(int v);
        logic [7:0] b = '0;
        for (int i = 0; i < 6; i++) b[7-i] = v[4+i];
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input bit ce, input logic [7:0] d, input bit wh, input bit wl, input bit wa);
        clock_enable = ce;
        bus_if.internal_data_bus = d;
        bus_if.write_frequency_h = wh;
        bus_if.write_frequency_l = wl;
        bus_if.write_attenuation = wa;
        @(posedge clock);
        model_edge(ce, d, wh, wl, wa);
        #1;
        chk("cycle_out", cycle_out, m_cyc);
        chk("analog_out", analog_out, m_amp);
        clock_enable = 0;
        bus_if.write_frequency_h = 0;
        bus_if.write_frequency_l = 0;
        bus_if.write_attenuation = 0;
    endtask

    // Enable on every 4th clock.
    task automatic wr(input bit wh, input bit wl, input bit wa, input logic [7:0] d);
        bit ce = (cyc_cnt % 4 == 3);
        cyc_cnt++;
        tick(ce, d, wh, wl, wa);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) wr(0, 0, 0, 8'h00);
    endtask

    task automatic set_freq(input int f);
        wr(1, 0, 0, enc_low4(f));
        wr(0, 1, 0, enc_high6(f));
    endtask

    // Clocks between two consecutive cycle_out pulses, bounded.
    task automatic measure_period(input string tag, input int exp);
        int t = 0;
        int guard = 0;
        while (cycle_out !== 1'b1 && guard < 1000) begin run(1); guard++; end
        run(1); t = 1;
        while (cycle_out !== 1'b1 && t < 1000) begin run(1); t++; end
        chk(tag, t, exp);
    endtask

    initial begin
        bus_if.internal_data_bus = 8'h00;
        bus_if.write_frequency_h = 0;
        bus_if.write_frequency_l = 0;
        bus_if.write_attenuation = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_cycle", cycle_out, 0);
        chk("rst_analog", analog_out, 0);
        #3 reset = 1;
        chk("rst_att", dut.attenuation, 15);
        chk("rst_freq", dut.frequency, 0);
        run(12);
        chk("idle_att", dut.attenuation, 15);

        // Attenuation 0, frequency 10: 40-clock half periods
        wr(0, 0, 1, 8'h00);
        wr(1, 0, 0, 8'h50);
        wr(0, 1, 0, 8'h00);
        chk("freq10", dut.frequency, 10);
        run(100);
        measure_period("period_f10", 40);
        measure_period("period_f10b", 40);

        // Frequency 32 written mid-period; old half period completes first
        run(17);
        set_freq(32);
        measure_period("period_f32", 128);
        measure_period("period_f32b", 128);

        // Attenuation sweep at frequency 10
        set_freq(10);
        run(300);
        for (int a = 0; a < 16; a++) begin
            wr(0, 0, 1, enc_low4(a));
            run(99);
        end

        // Frequency 0 and 1 toggle on every enable tick
        wr(0, 0, 1, 8'h00);
        set_freq(0);
        run(60);
        measure_period("period_f0", 4);
        set_freq(1);
        run(60);
        measure_period("period_f1", 4);

        // Random traffic, including simultaneous strobes
        for (int i = 0; i < 2000; i++) begin
            bit ce = ($urandom_range(0, 3) == 0);
            bit wh = ($urandom_range(0, 39) == 0);
            bit wl = ($urandom_range(0, 39) == 0);
            bit wa = ($urandom_range(0, 29) == 0);
            logic [7:0] d = 8'($urandom);
            if (wh || wl) d[1:0] = 2'($urandom);
            if ((wh || wl) && $urandom_range(0, 1) == 1) d[7:2] = 6'h00;
            tick(ce, d, wh, wl, wa);
        end

        // Async reset while the output is high
        wr(0, 0, 1, 8'h00);
        set_freq(10);
        begin
            int guard = 0;
            while (m_amp != 63 && guard < 400) begin run(1); guard++; end
            chk("pre_reset_amp", analog_out, 63);
        end
        #2 reset = 0;
        #1;
        chk("async_cycle", cycle_out, 0);
        chk("async_analog", analog_out, 0);
        model_reset();
        repeat (2) @(posedge clock);
        #2 reset = 1;
        chk("post_rst_att", dut.attenuation, 15);
        chk("post_rst_freq", dut.frequency, 0);
        run(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kf76489_tone_channel.md
Name: kf76489_tone_channel

Overview:
- One square-wave tone channel of an SN76489-compatible PSG.
- A 10-bit divider, advanced by the shared `clock_enable` tick, toggles an output flip-flop. The flip-flop level is scaled by a 4-bit attenuation (2 dB/step) into a 6-bit amplitude.
- Sits behind the register decoder, which drives the shared 8-bit internal bus and per-register write strobes.
- `cycle_out` feeds the noise generator, which can use tone-3 rate.

Parameters:
- none

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (`reset`=0 resets the block).
- `clock_enable`  in  1  divider tick, one clock wide (nominally 1 in 4 clocks).
- `internal_data_bus`  in  8  write data, TI bit order (bus[7] = chip D0).
- `write_frequency_h`  in  1  strobe: latch frequency bits [3:0].
- `write_frequency_l`  in  1  strobe: latch frequency bits [9:4].
- `write_attenuation`  in  1  strobe: latch attenuation [3:0].
- `cycle_out`  out  1  one-clock pulse at every divider reload.
- `analog_out`  out  6  channel amplitude, unsigned.

Behaviour:
- Reset (async, active-low) values:
  - frequency = 0, attenuation = 4'hF, counter = 0, tone flip-flop = 0.
  - `cycle_out` = 0, `analog_out` = 0.
- Register writes happen on any clock edge with the strobe high, independent of `clock_enable`. The bus is bit-reversed within each field:
  - `write_frequency_h`: freq[0]=bus[7], freq[1]=bus[6], freq[2]=bus[5], freq[3]=bus[4]. Bus[3:0] is ignored.
  - `write_frequency_l`: freq[4]=bus[7], freq[5]=bus[6], freq[6]=bus[5], freq[7]=bus[4], freq[8]=bus[3], freq[9]=bus[2]. Bus[1:0] is ignored.
  - `write_attenuation`: att[0]=bus[7], att[1]=bus[6], att[2]=bus[5], att[3]=bus[4].
  - Simultaneous `_h` and `_l` strobes update both fields in the same edge.
- Divider, evaluated only on edges with `clock_enable`=1:
  - If counter <= 1: counter <= freq, toggle the flip-flop, `cycle_out` <= 1.
  - Otherwise: counter <= counter-1, `cycle_out` <= 0.
  - On edges with `clock_enable`=0, `cycle_out` <= 0.
- Half-period = max(freq,1) enable ticks; freq 0 behaves as 1.
- A frequency write does not restart the counter. The new value takes effect at the next reload.
- Output stage is registered, updated every clock (1-clock latency):
  - `analog_out` <= flip-flop ? VOL[att] : 0.
  - Attenuation changes are visible on the clock after the write edge.
- VOL table (att 0..15): 63, 50, 40, 32, 25, 20, 16, 13, 10, 8, 6, 5, 4, 3, 3, 0. Attenuation 15 is silence.
- Reset asserted mid-operation immediately clears all state to the reset values.

Decomposition:
- Shared package `kf76489_pkg`:
  - 64-entry-capable 6-bit volume table constant (16 entries used).
  - Field widths: FREQ_W=10, ATT_W=4, AMP_W=6.
  - Bit-reverse helper function, reused by the noise channel.
- No sub-module; divider plus output register is a single flat block.

Test Plan:
- Reset, 12 clocks idle, no writes -> `analog_out`=0 and `cycle_out`=0 throughout; attenuation reads back as 15.
- Attenuation 0, frequency 10 (bus 8'h50 with `_h`, then 8'h00 with `_l`), enable every 4th clock -> `cycle_out` pulses every 10 enables (40 clocks); `analog_out` alternates 0/63 with 40-clock half-periods.
- Write frequency 32 mid-period -> current half-period completes at the old value; subsequent half-periods are 32 enables (128 clocks).
- Step attenuation 0..15, 100 clocks each, frequency 10 -> high-phase amplitude follows 63, 50, 40, 32, 25, 20, 16, 13, 10, 8, 6, 5, 4, 3, 3, 0; low phase is always 0; each change lands 1 clock after the write.
- Frequency 0 and frequency 1 -> toggle on every enable tick; `cycle_out` pulses on every tick.
- Drop reset (drive `reset` to 0) while `analog_out`=63 -> outputs go to 0 immediately (async); after release, frequency=0 and attenuation=15.
